uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1 (8E1 with parity compiled in), LSB first. It samples the `rx` pin at mid-bit using a cycle-accurate baud counter and delivers each received byte on a `StreamBus` source port. It is the receive-side counterpart of `uart_tx` and sits between the board RX pin and any `StreamBus` consumer.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/stream_bus.sv | 17 +
 rtl/uart_baud_cnt.sv | 27 ++
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for uart_rx / uart_tx.
// UART_RX_PARITY_EN adds the PARITY receive state.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int IDX_W = $clog2(UART_DATA_BITS);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_RX_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_HIGH
    } uart_rx_state_t;

    function automatic int uart_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/stream_bus.sv
// Valid/ready byte stream with source and sink views.
// clk/rst travel with the bus for consumers that need them.
interface StreamBus #(
    parameter int W = 8
) (
    input logic clk,
    input logic rst
);

    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport source (input clk, rst, ready, output valid, data);
    modport sink   (input clk, rst, valid, data, output ready);

endinterface

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter; expire is high while the count sits at zero.
// It parks at zero when not reloaded.
module uart_baud_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry output register.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 8_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rx,
    StreamBus.source bus,
    output logic     frame_err,
    output logic     overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic     parity_err
`endif
);

    localparam int DIV = uart_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(UART_DATA_BITS - 1);

    if (DIV < 4) begin : g_div_chk
        $error("uart_rx: CLK_HZ / BAUD must be at least 4");
    end

    uart_rx_state_t state, nxt;

    logic [1:0]                sync;
    logic                      rxs;
    logic                      expire;
    logic                      load;
    logic [CW-1:0]             load_val;
    logic                      clr_idx;
    logic                      shift_en;
    logic                      frame_bad;
    logic                      byte_ok;
    logic                      accept;
    logic [IDX_W-1:0]          idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      pflag;
`ifdef UART_RX_PARITY_EN
    logic                      par_chk;
    logic                      parity_bad;
`endif

    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rx};
    end

    assign rxs = sync[1];

    uart_baud_cnt #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= RX_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            RX_IDLE:      if (!rxs) nxt = RX_START;
            RX_START:     if (expire) nxt = rxs ? RX_IDLE : RX_DATA;
`ifdef UART_RX_PARITY_EN
            RX_DATA:      if (expire && idx == LAST) nxt = RX_PARITY;
            RX_PARITY:    if (expire) nxt = RX_STOP;
`else
            RX_DATA:      if (expire && idx == LAST) nxt = RX_STOP;
`endif
            RX_STOP:      if (expire) nxt = rxs ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rxs) nxt = RX_IDLE;
            default:      nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        load      = 1'b0;
        load_val  = FULL;
        clr_idx   = 1'b0;
        shift_en  = 1'b0;
        frame_bad = 1'b0;
        byte_ok   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk    = 1'b0;
        parity_bad = 1'b0;
`endif
        unique case (state)
            RX_IDLE: begin
                load     = !rxs;
                load_val = HALF;
            end
            RX_START: begin
                load    = expire && !rxs;
                clr_idx = expire && !rxs;
            end
            RX_DATA: begin
                load     = expire;
                shift_en = expire;
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                load    = expire;
                par_chk = expire;
            end
`endif
            RX_STOP: begin
                frame_bad = expire && !rxs;
                byte_ok   = expire && rxs && !pflag;
`ifdef UART_RX_PARITY_EN
                parity_bad = expire && rxs && pflag;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            shreg <= '0;
        end else if (clr_idx) begin
            idx <= '0;
        end else if (shift_en) begin
            shreg[idx] <= rxs;
            idx        <= idx + IDX_W'(1);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit must match the XOR of the data bits.
    always_ff @(posedge clk) begin
        if (rst || clr_idx) pflag <= 1'b0;
        else if (par_chk && (rxs != ^shreg)) pflag <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= parity_bad;
    end
`else
    assign pflag = 1'b0;
`endif

    assign accept = byte_ok && (!bus.valid || bus.ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid <= 1'b0;
            bus.data  <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept) begin
                bus.valid <= 1'b1;
                bus.data  <= shreg;
            end else if (bus.ready) begin
                bus.valid <= 1'b0;
            end
            frame_err <= frame_bad;
            overrun   <= byte_ok && !accept;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV = 8.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int CLK_HZ = 8_000_000;
    localparam int BAUD   = 1_000_000;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic ready = 1'b1;
    logic frame_err;
    logic overrun;
`ifdef UART_RX_PARITY_EN
    logic parity_err;
`endif

    StreamBus bus_if (.clk(clk), .rst(rst));
    assign bus_if.ready = ready;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .bus       (bus_if),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int rise_cyc = -1;
    int fe_n = 0;
    int ov_n = 0;
    int pe_n = 0;
    logic vprev = 1'b0;
    logic [7:0] got[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: received bytes, valid rise time and error pulse counts.
    always @(negedge clk) begin
        if (rst) begin
            vprev <= 1'b0;
        end else begin
            if (bus_if.valid && bus_if.ready) got.push_back(bus_if.data);
            if (bus_if.valid && !vprev) rise_cyc <= cyc;
            vprev <= bus_if.valid;
            fe_n <= fe_n + int'(frame_err);
            ov_n <= ov_n + int'(overrun);
`ifdef UART_RX_PARITY_EN
            pe_n <= pe_n + int'(parity_err);
`endif
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic pflip);
        logic [NBITS-1:0] f;
`ifdef UART_RX_PARITY_EN
        f = {stop, (^b) ^ pflip, b, 1'b0};
`else
        f = {stop, b, 1'b0};
        if (pflip) f = {stop, b, 1'b0};
`endif
        fall_cyc = cyc;
        for (int i = 0; i < NBITS; i++) begin
            rx = f[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_if.valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b want 0", bus_if.valid);
        end
        checks++;
        if (bus_if.data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got %h want 00", bus_if.data);
        end
        checks++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses: got fe=%b ov=%b want 0 0",
                     frame_err, overrun);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_frame_ab;
        int n0 = got.size();
        int f0 = fe_n, o0 = ov_n, p0 = pe_n;
        int lat = 2 + DIV / 2 + (NBITS - 1) * DIV + 1;
        send_frame(8'hAB, 1'b1, 1'b0);
        idle(2 * DIV);
        checks++;
        if (got.size() != n0 + 1 || got[got.size()-1] !== 8'hAB) begin
            failures++;
            $display("FAIL ab_data: got n=%0d want n=%0d byte AB",
                     got.size() - n0, 1);
        end
        checks++;
        if (rise_cyc - fall_cyc != lat) begin
            failures++;
            $display("FAIL ab_latency: got %0d want %0d",
                     rise_cyc - fall_cyc, lat);
        end
        checks++;
        if (fe_n != f0 || ov_n != o0 || pe_n != p0) begin
            failures++;
            $display("FAIL ab_pulses: got fe=%0d ov=%0d pe=%0d want 0",
                     fe_n - f0, ov_n - o0, pe_n - p0);
        end
    endtask

    task automatic test_false_start;
        int n0 = got.size();
        int f0 = fe_n, o0 = ov_n, p0 = pe_n;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(3 * DIV);
        checks++;
        if (got.size() != n0 || bus_if.valid !== 1'b0) begin
            failures++;
            $display("FAIL glitch_valid: got n=%0d valid=%b want 0 0",
                     got.size() - n0, bus_if.valid);
        end
        checks++;
        if (fe_n != f0 || ov_n != o0 || pe_n != p0) begin
            failures++;
            $display("FAIL glitch_pulses: got fe=%0d ov=%0d pe=%0d want 0",
                     fe_n - f0, ov_n - o0, pe_n - p0);
        end
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(2 * DIV);
        checks++;
        if (got.size() != n0 + 1 || got[got.size()-1] !== 8'h5A) begin
            failures++;
            $display("FAIL glitch_recover: got n=%0d want 1 byte 5A",
                     got.size() - n0);
        end
    endtask

    task automatic test_frame_err;
        int n0 = got.size();
        int f0 = fe_n;
        send_frame(8'h55, 1'b0, 1'b0);
        idle(3 * DIV);
        checks++;
        if (fe_n - f0 != 1 || got.size() != n0) begin
            failures++;
            $display("FAIL frame_err: got fe=%0d n=%0d want 1 0",
                     fe_n - f0, got.size() - n0);
        end
        send_frame(8'h12, 1'b1, 1'b0);
        idle(2 * DIV);
        checks++;
        if (got.size() != n0 + 1 || got[got.size()-1] !== 8'h12) begin
            failures++;
            $display("FAIL frame_err_next: got n=%0d want 1 byte 12",
                     got.size() - n0);
        end
    endtask

    task automatic test_overrun;
        int n0 = got.size();
        int o0 = ov_n;
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(DIV);
        checks++;
        if (bus_if.valid !== 1'b1 || bus_if.data !== 8'h11) begin
            failures++;
            $display("FAIL ovr_hold: got v=%b d=%h want 1 11",
                     bus_if.valid, bus_if.data);
        end
        checks++;
        if (ov_n - o0 != 1) begin
            failures++;
            $display("FAIL ovr_pulse: got %0d want 1", ov_n - o0);
        end
        ready = 1'b1;
        idle(4);
        checks++;
        if (got.size() != n0 + 1 || got[got.size()-1] !== 8'h11) begin
            failures++;
            $display("FAIL ovr_drain: got n=%0d want 1 byte 11",
                     got.size() - n0);
        end
        checks++;
        if (bus_if.valid !== 1'b0) begin
            failures++;
            $display("FAIL ovr_valid: got %b want 0", bus_if.valid);
        end
    endtask

    task automatic test_reset_mid;
        int n0 = got.size();
        int f0 = fe_n, o0 = ov_n, p0 = pe_n;
        logic [7:0] b = 8'hF0;
        rx = 1'b0;
        repeat (DIV) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        rx = b[4];
        repeat (DIV / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_if.valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_valid: got %b want 0", bus_if.valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2 * DIV);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(2 * DIV);
        checks++;
        if (got.size() != n0 + 1 || got[got.size()-1] !== 8'h3C) begin
            failures++;
            $display("FAIL rst_mid_data: got n=%0d want 1 byte 3C",
                     got.size() - n0);
        end
        checks++;
        if (fe_n != f0 || ov_n != o0 || pe_n != p0) begin
            failures++;
            $display("FAIL rst_mid_pulses: got fe=%0d ov=%0d pe=%0d want 0",
                     fe_n - f0, ov_n - o0, pe_n - p0);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int n0 = got.size();
        int p0 = pe_n;
        send_frame(8'hAB, 1'b1, 1'b1);
        idle(2 * DIV);
        checks++;
        if (pe_n - p0 != 1 || got.size() != n0) begin
            failures++;
            $display("FAIL parity_err: got pe=%0d n=%0d want 1 0",
                     pe_n - p0, got.size() - n0);
        end
    endtask
`endif

    // Random bytes with random idle gaps, including zero-gap frames.
    task automatic test_random;
        logic [7:0] exp_q[$];
        int n0 = got.size();
        int f0 = fe_n, o0 = ov_n, p0 = pe_n;
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1, 1'b0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 12));
        end
        idle(2 * DIV);
        checks++;
        if (got.size() - n0 != exp_q.size()) begin
            failures++;
            $display("FAIL rand_count: got %0d want %0d",
                     got.size() - n0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got[n0 + i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand_byte[%0d]: got %h want %h",
                             i, got[n0 + i], exp_q[i]);
                end
            end
        end
        checks++;
        if (fe_n != f0 || ov_n != o0 || pe_n != p0) begin
            failures++;
            $display("FAIL rand_pulses: got fe=%0d ov=%0d pe=%0d want 0",
                     fe_n - f0, ov_n - o0, pe_n - p0);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset;
        test_frame_ab;
        test_false_start;
        test_frame_err;
        test_overrun;
        test_reset_mid;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
